gba_bw_frame_sequencer: RTL and testbench
=========================================

Name: gba_bw_frame_sequencer

Overview:
Sequences reads of a 1bpp black/white intro image held across NUM_BANKS initialized block-RAM banks of 512 x 8 bits each. It walks the image byte by byte and routes each read to the correct bank. Each returned byte is unpacked MSB-first into a ready/valid pixel stream with frame and line markers. It sits between the image ROM banks and the display/scan-out logic, and is the only requester of the banks.

Parameters:
NUM_BANKS, 2, number of 512-byte image banks (bank 0 holds bytes 0-511, bank 1 holds 512-1023, ...)
IMG_W, 128, image width in pixels; must be a multiple of 8
IMG_H, 48, image height in lines; IMG_W*IMG_H/8 must be <= NUM_BANKS*512

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins one frame when idle
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last pixel is accepted
bank_rd_en  out  NUM_BANKS  one-hot read enable, one bit per bank
bank_rd_addr  out  9  byte address within the selected bank; shared by all banks
bank_data_in  in  NUM_BANKS*8  concatenated bank outputs; bank k occupies bits [8k+7:8k]
bank_valid_in  in  NUM_BANKS  per-bank read-valid
pix_valid  out  1  pixel available
pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready
pix_data  out  1  pixel value (1 = white)
pix_sof  out  1  qualifies the first pixel of the frame
pix_eol  out  1  qualifies the last pixel of each line
pix_eof  out  1  qualifies the last pixel of the frame

Behaviour:
- Reset: all outputs 0; FSM = IDLE; byte counter, pixel counters, shifter and prefetch buffer cleared; any outstanding read discarded.
- Byte index b runs 0..TOTAL-1, where TOTAL = IMG_W*IMG_H/8.
  - Bank select = b / 512; address = b % 512.
  - bank_rd_en is one-hot on the selected bank for exactly one cycle per read.
  - bank_rd_addr holds its value whenever no read is issued.
- Bank timing: a read issued in cycle T returns data in cycle T+1, qualified by bank_valid_in[sel].
  - Data is captured only from the addressed bank, and only while a read is outstanding.
  - Valid from any other bank is ignored.
  - If valid does not arrive, the controller waits indefinitely; at most one read is outstanding.
- FSM states:
  - IDLE: start=1 → FETCH; busy rises the next cycle. start while busy is ignored.
  - FETCH: issue the read for byte 0 → WAIT.
  - WAIT: on valid, load the shifter (8 bits, cursor 7) → STREAM.
  - STREAM: pix_data = shifter[cursor]; on acceptance, cursor decrements. When the last bit is accepted:
    - prefetch full → load shifter from prefetch in the same cycle; no bubble.
    - prefetch empty and bytes remain → WAIT.
    - frame complete → DONE.
  - DONE: done=1 for one cycle, busy drops → IDLE.
- Prefetch: in STREAM, when the prefetch buffer is empty, no read is outstanding and bytes remain, issue the next read. The returned byte fills prefetch.
- Throughput: with pix_ready held at 1, the stream is 1 pixel/cycle with no gaps between bytes.
- Latency: start sampled at edge E → bank_rd_en in cycle E+1 → first pix_valid in cycle E+3.
- Stall rule: while pix_valid && !pix_ready, pix_data, pix_sof, pix_eol and pix_eof stay stable and pix_valid stays high.
- Markers:
  - x counts 0..IMG_W-1 and y counts 0..IMG_H-1, advancing on acceptance; x wraps to 0 and y increments at line end.
  - pix_sof = (x==0 && y==0); pix_eol = (x==IMG_W-1); pix_eof = pix_eol && (y==IMG_H-1).
- Bank boundary: byte 511 → byte 512 switches bank_rd_en from bit 0 to bit 1, with address wrapping 511→0. No bubble at the crossing.
- Reset mid-frame: returns to IDLE immediately. A bank valid arriving the cycle after reset is ignored.
- Bank contents beyond TOTAL are never read.

Test Plan:
- Reset, then start pulse with pix_ready=1 → bank_rd_en=2'b01 and addr=0 one cycle later; pix_valid 3 cycles after start; 6144 consecutive pixels; done pulses once; busy low afterwards.
- Bank 0 byte 0 = 8'b00000001 → pixels 0,0,0,0,0,0,0,1 in order; pix_sof only on the first pixel.
- Pixel 127 → pix_eol=1; pixel 6143 → pix_eol=pix_eof=1; no other pixels carry eol/eof.
- Bank crossing: read of byte 511 uses rd_en=01/addr=511; next read uses rd_en=10/addr=0; bank 1 data appears at pixel 4096 with no gap.
- Random pix_ready toggling plus delayed bank valid → pixel sequence identical to golden image; outputs stable during stalls; valid from the unaddressed bank is ignored.
- rst asserted mid-frame → all outputs 0 next cycle; a start pulse issued while busy is ignored; a new start after reset restarts from byte 0 with pix_sof.

Source files
------------

// File: rtl/gba_bw_frame_sequencer.sv
// Walks a 1bpp image stored across 512-byte ROM banks and streams it MSB-first
// as ready/valid pixels with frame/line markers; one-byte prefetch hides read latency.
module gba_bw_frame_sequencer #(
  parameter int NUM_BANKS = 2,
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_BANKS-1:0]   bank_rd_en,
  output logic [8:0]             bank_rd_addr,
  input  logic [NUM_BANKS*8-1:0] bank_data_in,
  input  logic [NUM_BANKS-1:0]   bank_valid_in,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   pix_data,
  output logic                   pix_sof,
  output logic                   pix_eol,
  output logic                   pix_eof
);
  localparam int TOTAL = IMG_W * IMG_H / 8;
  localparam int SW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int IW    = 10 + SW;
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_STREAM, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [8:0]      addr_q, addr_d;
  logic            rd_pend_q, rd_pend_d;
  logic [SW-1:0]   rd_sel_q, rd_sel_d;
  logic [7:0]      sh_q, sh_d;
  logic [2:0]      cur_q, cur_d;
  logic [7:0]      pf_q, pf_d;
  logic            pf_full_q, pf_full_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;

  logic            capture, accept, last_bit, eol, eof, remain, issue;
  logic [7:0]      cap_byte;
  logic [SW-1:0]   sel;

  always_comb begin
    sel      = rd_idx_q[9 +: SW];
    capture  = rd_pend_q && bank_valid_in[rd_sel_q];
    cap_byte = bank_data_in[{rd_sel_q, 3'b000} +: 8];
    accept   = (state_q == S_STREAM) && pix_ready;
    last_bit = accept && (cur_q == 3'd0);
    eol      = (x_q == XW'(IMG_W - 1));
    eof      = eol && (y_q == YW'(IMG_H - 1));
    remain   = rd_idx_q < IW'(TOTAL);
    // Only one read in flight, and never while the prefetch slot is occupied.
    issue    = (state_q == S_FETCH) ||
               (((state_q == S_STREAM) || (state_q == S_WAIT)) &&
                !pf_full_q && !rd_pend_q && remain);

    bank_rd_en   = issue ? (NUM_BANKS'(1) << sel) : '0;
    bank_rd_addr = issue ? rd_idx_q[8:0] : addr_q;
    busy         = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_STREAM);
    done         = (state_q == S_DONE);
    pix_valid    = (state_q == S_STREAM);
    pix_data     = pix_valid && sh_q[cur_q];
    pix_sof      = pix_valid && (x_q == '0) && (y_q == '0);
    pix_eol      = pix_valid && eol;
    pix_eof      = pix_valid && eof;
  end

  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    addr_d    = addr_q;
    rd_pend_d = rd_pend_q;
    rd_sel_d  = rd_sel_q;
    sh_d      = sh_q;
    cur_d     = cur_q;
    pf_d      = pf_q;
    pf_full_d = pf_full_q;
    x_d       = x_q;
    y_d       = y_q;

    if (issue) begin
      rd_idx_d  = rd_idx_q + IW'(1);
      addr_d    = rd_idx_q[8:0];
      rd_pend_d = 1'b1;
      rd_sel_d  = sel;
    end
    if (capture) rd_pend_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          rd_idx_d  = '0;
          pf_full_d = 1'b0;
          x_d       = '0;
          y_d       = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (capture) begin
          sh_d    = cap_byte;
          cur_d   = 3'd7;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (capture && !last_bit) begin
          pf_d      = cap_byte;
          pf_full_d = 1'b1;
        end
        if (accept) begin
          if (eol) begin
            x_d = '0;
            y_d = eof ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (!last_bit) begin
            cur_d = cur_q - 3'd1;
          end else if (eof) begin
            state_d = S_DONE;
          end else if (pf_full_q) begin
            sh_d      = pf_q;
            cur_d     = 3'd7;
            pf_full_d = 1'b0;
          end else if (capture) begin
            // Byte landing exactly as the shifter drains goes straight in.
            sh_d  = cap_byte;
            cur_d = 3'd7;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_idx_q  <= '0;
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_sel_q  <= '0;
      sh_q      <= '0;
      cur_q     <= '0;
      pf_q      <= '0;
      pf_full_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      rd_idx_q  <= rd_idx_d;
      addr_q    <= addr_d;
      rd_pend_q <= rd_pend_d;
      rd_sel_q  <= rd_sel_d;
      sh_q      <= sh_d;
      cur_q     <= cur_d;
      pf_q      <= pf_d;
      pf_full_q <= pf_full_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end
endmodule

// File: tb/tb_gba_bw_frame_sequencer.sv
// Bench for gba_bw_frame_sequencer: bank responder with random latency and stray
// valids, pixel stream compared against the image unpacked by plain arithmetic.
module tb_gba_bw_frame_sequencer;
  localparam int NB    = 2;
  localparam int W     = 128;
  localparam int H     = 48;
  localparam int TOTAL = W * H / 8;
  localparam int NPIX  = W * H;

  logic              clk = 1'b0;
  logic              rst, start, busy, done;
  logic [NB-1:0]     bank_rd_en, bank_valid_in;
  logic [8:0]        bank_rd_addr;
  logic [NB*8-1:0]   bank_data_in;
  logic              pix_valid, pix_ready, pix_data, pix_sof, pix_eol, pix_eof;

  logic [7:0] img [0:NB*512-1];
  int  checks = 0;
  int  errors = 0;
  bit  rnd_mode = 1'b0;
  bit  pend = 1'b0;
  int  pbank = 0, pidx = 0, dly = 0;

  always #5 clk = ~clk;

  gba_bw_frame_sequencer #(.NUM_BANKS(NB), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
    .bank_data_in(bank_data_in), .bank_valid_in(bank_valid_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_img();
    for (int i = 0; i < NB*512; i++) img[i] = 8'($urandom);
  endtask

  // Bank model: answers a read one cycle later (plus random latency in random mode),
  // with garbage data and stray valids on banks that are not being waited on.
  initial begin
    bank_valid_in = '0;
    bank_data_in  = '0;
    forever begin
      @(posedge clk); #1;
      bank_valid_in = '0;
      bank_data_in  = NB*8'($urandom);
      if (pend) begin
        if (dly == 0) begin
          bank_valid_in[pbank]       = 1'b1;
          bank_data_in[pbank*8 +: 8] = img[pidx];
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
      if (rnd_mode)
        for (int k = 0; k < NB; k++)
          if (!(pend && k == pbank) && $urandom_range(0, 3) == 0) bank_valid_in[k] = 1'b1;
      if (bank_rd_en != '0) begin
        for (int k = 0; k < NB; k++) if (bank_rd_en[k]) pbank = k;
        pidx = pbank * 512 + int'(bank_rd_addr);
        dly  = rnd_mode ? $urandom_range(0, 3) : 0;
        pend = 1'b1;
      end
    end
  end

  task automatic run_frame(input bit rnd, input int abort_at);
    int p, r, cyc, dones;
    logic [8:0] last_addr;
    logic [7:0] b;
    logic [3:0] prev_out;
    bit pv_prev, pr_prev, rdy;
    p = 0; r = 0; cyc = 0; dones = 0; last_addr = '0;
    pv_prev = 1'b0; pr_prev = 1'b0; prev_out = '0;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("first_rd_en", bank_rd_en, 1);
    while (cyc < 40000) begin
      if (bank_rd_en != '0) begin
        chk("rd_en", bank_rd_en, 32'(NB'(1) << (r / 512)));
        chk("rd_addr", bank_rd_addr, r % 512);
        last_addr = 9'(r % 512);
        r++;
      end else if (r > 0) begin
        chk("addr_hold", bank_rd_addr, last_addr);
      end
      if (!rnd && cyc < 2) chk("latency_no_pix", pix_valid, 0);
      if (!rnd && cyc >= 2 && p < NPIX) chk("no_gap", pix_valid, 1);
      if (pv_prev && !pr_prev) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_stable", {pix_data, pix_sof, pix_eol, pix_eof}, prev_out);
      end
      if (pix_valid) begin
        if (p >= NPIX) begin
          chk("extra_pix", pix_valid, 0);
        end else begin
          b = img[p / 8];
          chk("pix_data", pix_data, b[7 - (p % 8)]);
          chk("pix_sof", pix_sof, p == 0);
          chk("pix_eol", pix_eol, (p % W) == W - 1);
          chk("pix_eof", pix_eof, p == NPIX - 1);
        end
      end
      if (done) begin
        dones++;
        chk("done_after_last", p, NPIX);
        chk("busy_at_done", busy, 0);
        break;
      end
      if (abort_at > 0 && cyc == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("rst_mid_outs", {bank_rd_en, bank_rd_addr, busy, done, pix_valid,
                             pix_data, pix_sof, pix_eol, pix_eof}, 0);
        return;
      end
      start = (abort_at > 0 && cyc == abort_at / 2);
      rdy = rnd ? ($urandom_range(0, 99) < 60) : 1'b1;
      pix_ready = rdy;
      if (pix_valid && rdy) p++;
      pv_prev  = pix_valid;
      pr_prev  = rdy;
      prev_out = {pix_data, pix_sof, pix_eol, pix_eof};
      @(posedge clk); #2;
      cyc++;
    end
    start = 1'b0;
    chk("frame_done_seen", dones, 1);
    @(posedge clk); #2;
    chk("done_one_cycle", done, 0);
    chk("busy_after", busy, 0);
    chk("idle_no_pix", pix_valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    fill_img();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset_outs", {bank_rd_en, bank_rd_addr, busy, done, pix_valid,
                       pix_data, pix_sof, pix_eol, pix_eof}, 0);
    @(posedge clk); #2;
    chk("idle_busy", busy, 0);

    // Full-rate frame; byte 0 = 0x01 gives seven 0 pixels then a 1.
    img[0] = 8'h01;
    run_frame(1'b0, 0);

    // Random backpressure, bank latency and stray valids.
    rnd_mode = 1'b1;
    fill_img();
    run_frame(1'b1, 0);

    // Reset mid-frame, with a start pulse issued while busy beforehand.
    fill_img();
    run_frame(1'b1, 700);
    repeat (6) begin
      @(posedge clk); #2;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_pix", pix_valid, 0);
      chk("post_rst_rd", bank_rd_en, 0);
    end

    // Restart after reset begins again at byte 0 with pix_sof.
    fill_img();
    run_frame(1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
